// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared defaults, signed max and clog2 helpers for the max-pooling stage.
package maxpool_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HEIGHT = 8;
    localparam int DEF_POOL = 2;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int OUT_W = DEF_WIDTH / DEF_POOL;
    localparam int OUT_H = DEF_HEIGHT / DEF_POOL;
    localparam int COL_W = clog2(DEF_WIDTH);
    localparam int ROW_W = clog2(DEF_HEIGHT);

    // Operands are sign-extended to 32 bits, so any DATA_W up to 32 compares correctly.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/maxpool_if.sv
// maxpool_if: pixel stream in, pooled stream and frame-done pulse out.
interface maxpool_if import maxpool_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
    logic valid_in;
    logic signed [DATA_W-1:0] data_in;
    logic valid_out;
    logic signed [DATA_W-1:0] data_out;
    logic done;
    modport master(output valid_in, data_in, input valid_out, data_out, done);
    modport slave(input valid_in, data_in, output valid_out, data_out, done);
endinterface

// File: rtl/maxpool_row_buffer.sv
// maxpool_row_buffer: one partial vertical max per output column, shared read/write index.
module maxpool_row_buffer #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W = 2
) (
    input  logic                     clk,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic                     wr_en_i,
    input  logic signed [DATA_W-1:0] wdata_i,
    output logic signed [DATA_W-1:0] rdata_o
);
    logic signed [DATA_W-1:0] mem_q [DEPTH];
    assign rdata_o = mem_q[idx_i];
    always_ff @(posedge clk)
        if (wr_en_i) mem_q[idx_i] <= wdata_i;
endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming non-overlapping POOLxPOOL signed max-pool with frame-done pulse.
// Define RELU_EN to clamp pooled results at zero (fused ReLU).
module maxpool_stream import maxpool_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int POOL = DEF_POOL
) (
    input logic clk,
    input logic reset,
    maxpool_if.slave bus
);
    localparam int OW = WIDTH / POOL;
    localparam int OH = HEIGHT / POOL;
    localparam int CW = clog2(WIDTH);
    localparam int RW = clog2(HEIGHT);
    localparam int GW = clog2(OW);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic signed [DATA_W-1:0] hmax_q, hmax_d, data_out_q, data_out_d;
    logic signed [DATA_W-1:0] h, rd, wdata, pooled, out_val;
    logic valid_out_q, valid_out_d, done_q, done_d;
    logic wr_en, win, last_col, last_row;
    logic [31:0] c, r;
    logic [GW-1:0] g;

    maxpool_row_buffer #(.DEPTH(OW), .DATA_W(DATA_W), .IDX_W(GW)) u_rowbuf (
        .clk(clk), .idx_i(g), .wr_en_i(wr_en), .wdata_i(wdata), .rdata_o(rd)
    );

    always_comb begin
        c = 32'(col_q);
        r = 32'(row_q);
        last_col = c == WIDTH - 1;
        last_row = r == HEIGHT - 1;
        h = c % POOL == 0 ? bus.data_in : DATA_W'(smax(hmax_q, bus.data_in));
        g = c < OW * POOL ? GW'(c / POOL) : '0;
        // Trailing partial windows are counted by the counters but never touch the row buffer.
        wr_en = bus.valid_in && c % POOL == POOL - 1 && c < OW * POOL && r < OH * POOL;
        win = wr_en && r % POOL == POOL - 1;
        pooled = DATA_W'(smax(rd, h));
        wdata = r % POOL == 0 ? h : pooled;
`ifdef RELU_EN
        out_val = DATA_W'(smax(pooled, 0));
`else
        out_val = pooled;
`endif
        col_d = bus.valid_in ? (last_col ? '0 : col_q + 1'b1) : col_q;
        row_d = bus.valid_in && last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
        hmax_d = bus.valid_in ? h : hmax_q;
        valid_out_d = win;
        data_out_d = win ? out_val : data_out_q;
        done_d = bus.valid_in && last_col && last_row;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            hmax_q <= '0;
            valid_out_q <= 1'b0;
            data_out_q <= '0;
            done_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            hmax_q <= hmax_d;
            valid_out_q <= valid_out_d;
            data_out_q <= data_out_d;
            done_q <= done_d;
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.data_out = data_out_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: directed frames on a 4x4 and a 5x5 instance, scoreboarded window maxima.
module tb_maxpool_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    maxpool_if #(.DATA_W(8)) b4();
    maxpool_if #(.DATA_W(8)) b5();

    maxpool_stream #(.DATA_W(8), .WIDTH(4), .HEIGHT(4), .POOL(2)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
    maxpool_stream #(.DATA_W(8), .WIDTH(5), .HEIGHT(5), .POOL(2)) dut5 (.clk(clk), .reset(reset), .bus(b5.slave));

    int tests = 0, fails = 0;
    int sel = 0, mw = 4, mh = 4, mc = 0, mr = 0;
    logic signed [7:0] frame [0:4][0:4];
    logic signed [7:0] q [$];
    logic signed [7:0] last_exp = 0;

    function automatic logic signed [7:0] mx(input logic signed [7:0] a, input logic signed [7:0] b);
        return a > b ? a : b;
    endfunction

    function automatic logic signed [7:0] act(input logic signed [7:0] x);
`ifdef RELU_EN
        return x < 0 ? 8'sd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(output logic vo, output logic signed [7:0] dout, output logic dn);
        vo = sel == 0 ? b4.valid_out : b5.valid_out;
        dout = sel == 0 ? b4.data_out : b5.data_out;
        dn = sel == 0 ? b4.done : b5.done;
    endtask

    task automatic step(input bit v, input logic signed [7:0] d);
        logic exp_vo, exp_done, vo, dn;
        logic signed [7:0] dout, e;
        b4.valid_in = 1'b0;
        b5.valid_in = 1'b0;
        if (sel == 0) begin b4.valid_in = v; b4.data_in = d; end
        else begin b5.valid_in = v; b5.data_in = d; end
        exp_vo = 1'b0;
        exp_done = 1'b0;
        if (v) begin
            frame[mr][mc] = d;
            if (mc % 2 == 1 && mr % 2 == 1 && mc < (mw / 2) * 2 && mr < (mh / 2) * 2) begin
                q.push_back(act(mx(mx(frame[mr-1][mc-1], frame[mr-1][mc]), mx(frame[mr][mc-1], frame[mr][mc]))));
                exp_vo = 1'b1;
            end
            exp_done = mc == mw - 1 && mr == mh - 1;
            if (mc == mw - 1) begin
                mc = 0;
                mr = mr == mh - 1 ? 0 : mr + 1;
            end else mc++;
        end
        @(posedge clk);
        #1;
        sample(vo, dout, dn);
        check("valid_out", vo, exp_vo);
        check("done", dn, exp_done);
        if (vo === 1'b1) begin
            if (q.size() == 0) check("extra_valid_out", 1, 0);
            else begin
                e = q.pop_front();
                last_exp = e;
                check("data_out", dout, e);
            end
        end else check("data_hold", dout, last_exp);
    endtask

    task automatic do_reset();
        logic vo, dn;
        logic signed [7:0] dout;
        b4.valid_in = 1'b0;
        b5.valid_in = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mc = 0;
        mr = 0;
        last_exp = 0;
        q.delete();
        sample(vo, dout, dn);
        check("reset_valid_out", vo, 0);
        check("reset_done", dn, 0);
        check("reset_data_out", dout, 0);
    endtask

    initial begin
        b4.valid_in = 1'b0; b4.data_in = '0;
        b5.valid_in = 1'b0; b5.data_in = '0;
        // Continuous ramp
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        step(1'b0, 8'sd0);
        // Negative background with one -1 per window at a different offset
        for (int i = 0; i < 16; i++) begin
            int rr, cc, k, pos;
            rr = i / 4; cc = i % 4;
            k = (rr / 2) * 2 + cc / 2;
            pos = (rr % 2) * 2 + cc % 2;
            step(1'b1, pos == k ? -8'sd1 : -8'sd3);
        end
        step(1'b0, 8'sd0);
        // Ramp with valid toggling
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i));
            step(1'b0, 8'sd99);
        end
        // Reset mid-frame, then a full ramp
        for (int i = 0; i < 6; i++) step(1'b1, 8'(i));
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        // Two ramps back to back, then a mixed-sign random frame
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i % 16));
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)));
        step(1'b0, 8'sd0);
        check("queue_empty_4x4", q.size(), 0);
        // 5x5 frame: trailing column/row counted but discarded
        sel = 1; mw = 5; mh = 5;
        do_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 8'(i));
        step(1'b0, 8'sd0);
        for (int i = 0; i < 25; i++) step(1'b1, 8'($urandom_range(0, 255)));
        step(1'b0, 8'sd0);
        check("queue_empty_5x5", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
